// File: rtl/rle_pkg.sv
// Definitions shared by the RLE encoder and the run-length decoder:
// FSM state encoding and the layout of a 16-bit {byte, count} entry.
package rle_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_REQ,
      S_RD_WAIT,
      S_EXPAND,
      S_WR,
      S_FLUSH,
      S_DONE
   } state_e;

   localparam int BYTE_MSB         = 15;
   localparam int BYTE_LSB         = 8;
   localparam int CNT_MSB          = 7;
   localparam int CNT_LSB          = 0;
   localparam int ENTRY_W          = 16;
   localparam int ENTRIES_PER_WORD = 2;
   localparam int BYTES_PER_WORD   = 4;

endpackage

// File: rtl/rld_pack.sv
// Four-lane little-endian byte assembler. word_o already includes the byte
// being pushed this cycle, so the caller can write a word the cycle it fills.
module rld_pack
   import rle_pkg::*;
(
   input  logic        clk,
   input  logic        nreset,
   input  logic        clr_i,
   input  logic        push_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        full_o,
   output logic        pend_o
);

   logic [31:0] data_q, data_d;
   logic [1:0]  lane_q, lane_d;

   always_comb begin
      data_d = data_q;
      lane_d = lane_q;
      if (push_i) begin
         data_d[{lane_q, 3'b000} +: 8] = byte_i;
         lane_d = lane_q + 2'd1;
      end
   end

   assign word_o = data_d;
   assign full_o = push_i && (lane_q == 2'(BYTES_PER_WORD - 1));
   assign pend_o = push_i || (lane_q != 2'd0);

   // Clearing zeroes the data so a partial flush has empty upper lanes.
   always_ff @(posedge clk) begin
      if (!nreset || clr_i) begin
         data_q <= '0;
         lane_q <= '0;
      end else begin
         data_q <= data_d;
         lane_q <= lane_d;
      end
   end

endmodule

// File: rtl/rld.sv
// Run-length decoder: reads {byte, count} entries from DPSRAM port A, expands
// them and writes the plaintext back packed four bytes per word.
module rld
   import rle_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int COUNT_W = 8
)
(
   input  logic              clk,
   input  logic              nreset,
   input  logic              start,
   input  logic [31:0]       rle_addr,
   input  logic [31:0]       rle_size,
   input  logic [31:0]       message_addr,
   output logic [31:0]       message_size,
   output logic              done,
   output logic              port_A_clk,
   output logic [ADDR_W-1:0] port_A_addr,
   output logic              port_A_we,
   output logic [31:0]       port_A_data_in,
   input  logic [31:0]       port_A_data_out
);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, addr_q, addr_d;
   logic [29:0]         words_q, words_d;
   logic [31:0]         word_q, word_d, msize_q, msize_d, wdata_q, wdata_d;
   logic [7:0]          byte_q, byte_d;
   logic [COUNT_W-1:0]  cnt_q, cnt_d;
   logic                hi_q, hi_d, wdone_q, wdone_d, we_q, we_d, done_q, done_d;
   logic                push, clr, accept, fin;
   logic [31:0]         pk_word;
   logic                pk_full, pk_pend;
   logic                unused_bits;

   assign unused_bits = ^{rle_addr[31:ADDR_W], message_addr[31:ADDR_W], rle_size[1:0]};

   rld_pack u_pack (
      .clk    (clk),
      .nreset (nreset),
      .clr_i  (clr),
      .push_i (push),
      .byte_i (byte_q),
      .word_o (pk_word),
      .full_o (pk_full),
      .pend_o (pk_pend)
   );

   always_comb begin
      state_d  = state_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      words_d  = words_q;
      word_d   = word_q;
      byte_d   = byte_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      wdone_d  = wdone_q;
      msize_d  = msize_q;
      push     = 1'b0;
      clr      = 1'b0;
      accept   = 1'b0;
      fin      = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               accept   = 1'b1;
               clr      = 1'b1;
               rd_ptr_d = rle_addr[ADDR_W-1:0];
               wr_ptr_d = message_addr[ADDR_W-1:0];
               words_d  = rle_size[31:2];
               msize_d  = '0;
               state_d  = (rle_size[31:2] == 30'd0) ? S_DONE : S_RD_REQ;
            end
         end
         S_RD_REQ: begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(BYTES_PER_WORD);
            words_d  = words_q - 30'd1;
            state_d  = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            word_d  = port_A_data_out;
            byte_d  = port_A_data_out[BYTE_MSB:BYTE_LSB];
            cnt_d   = port_A_data_out[CNT_MSB:CNT_LSB];
            hi_d    = 1'b0;
            state_d = S_EXPAND;
         end
         S_EXPAND: begin
            // The last byte of a run and the move to the next entry share a cycle.
            if (cnt_q != '0) begin
               push    = 1'b1;
               cnt_d   = cnt_q - COUNT_W'(1);
               msize_d = msize_q + 32'd1;
               fin     = (cnt_q == COUNT_W'(1));
            end else begin
               fin = 1'b1;
            end
            if (fin && !hi_q) begin
               hi_d   = 1'b1;
               byte_d = word_q[ENTRY_W+BYTE_MSB:ENTRY_W+BYTE_LSB];
               cnt_d  = word_q[ENTRY_W+CNT_MSB:ENTRY_W+CNT_LSB];
            end
            wdone_d = fin && hi_q;
            if (pk_full)
               state_d = S_WR;
            else if (fin && hi_q)
               state_d = (words_q != 30'd0) ? S_RD_REQ : S_FLUSH;
         end
         S_WR: begin
            clr      = 1'b1;
            wr_ptr_d = wr_ptr_q + ADDR_W'(BYTES_PER_WORD);
            if (wdone_q)
               state_d = (words_q != 30'd0) ? S_RD_REQ : S_FLUSH;
            else
               state_d = S_EXPAND;
         end
         S_FLUSH: begin
            clr     = 1'b1;
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Port outputs are registered from the next state so they line up with it.
   always_comb begin
      we_d    = (state_d == S_WR) || ((state_d == S_FLUSH) && pk_pend);
      addr_d  = we_d ? wr_ptr_d : rd_ptr_d;
      wdata_d = we_d ? pk_word : wdata_q;
      done_d  = (state_d == S_DONE) && !accept;
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q  <= S_IDLE;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         words_q  <= '0;
         word_q   <= '0;
         byte_q   <= '0;
         cnt_q    <= '0;
         hi_q     <= 1'b0;
         wdone_q  <= 1'b0;
         msize_q  <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         words_q  <= words_d;
         word_q   <= word_d;
         byte_q   <= byte_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         wdone_q  <= wdone_d;
         msize_q  <= msize_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         done_q   <= done_d;
      end
   end

   assign port_A_clk     = clk;
   assign port_A_addr    = addr_q;
   assign port_A_we      = we_q;
   assign port_A_data_in = wdata_q;
   assign message_size   = msize_q;
   assign done           = done_q;

endmodule

// File: doc/rld.md
Name: rld

Overview:
- Run-length decoder; sits directly downstream of the RLE encoder stage.
- Reads the encoder's compressed frame from DPSRAM port A and expands each {byte, count} entry back into plaintext.
- Writes the plaintext, packed four bytes per word, to a destination region of the same DPSRAM.
- Reports the exact decoded length in bytes and pulses a done flag.

Parameters:
- ADDR_W, 16, DPSRAM byte-address width; all address arithmetic is modulo 2^ADDR_W.
- COUNT_W, 8, width of the run-count field in each entry.

Ports:
- clk  in  1  system clock
- nreset  in  1  reset, synchronous, active-low
- start  in  1  begin decoding; sampled only when not busy
- rle_addr  in  32  byte address of the compressed frame; bits [15:0] used
- rle_size  in  32  compressed length in bytes; bits [1:0] ignored
- message_addr  in  32  byte address for the decoded output; bits [15:0] used
- message_size  out  32  decoded length in bytes, exact count
- done  out  1  frame decode complete
- port_A_clk  out  1  equals clk
- port_A_addr  out  16  DPSRAM address
- port_A_we  out  1  1 = write, 0 = read
- port_A_data_in  out  32  write data to DPSRAM
- port_A_data_out  in  32  read data from DPSRAM; valid one cycle after the address

Behaviour:
- Reset (nreset low at posedge clk):
  - state IDLE; done=0, port_A_we=0, port_A_addr=0, port_A_data_in=0, message_size=0.
  - All internal pointers and counters cleared.
  - Reset mid-frame aborts immediately; no further writes occur.
- Entry format (fixed by the encoder):
  - Each 32-bit word holds two 16-bit entries; the low half [15:0] is decoded first, then the high half [31:16].
  - Entry bits [15:8] = byte value, [7:0] = run count (0..255).
  - Count 0 is padding: it produces no output and is skipped.
- Output packing:
  - Byte n of the decoded stream goes to lane n%4; lane 0 = bits [7:0], little-endian.
  - Word address = message_addr + 4*(n/4).
- FSM states: IDLE, RD_REQ, RD_WAIT, EXPAND, WR, FLUSH, DONE.
  - IDLE/DONE + start:
    - Latch rd_ptr=rle_addr[15:0], wr_ptr=message_addr[15:0], words_left=rle_size>>2; clear message_size and done.
    - If words_left==0, go to DONE next cycle; otherwise go to RD_REQ.
  - RD_REQ: drive port_A_addr=rd_ptr, we=0. Then rd_ptr+=4, words_left-=1, go to RD_WAIT.
  - RD_WAIT: capture port_A_data_out into the word register; select the low entry; go to EXPAND.
  - EXPAND: one cycle per output byte.
    - If the current entry's remaining count is >0: place the byte in the next lane and decrement the count; message_size increments by 1 per byte.
    - When lane 3 is filled, go to WR.
    - When the entry is exhausted, or its count is 0: advance low to high, then to the next word (RD_REQ if words_left>0, else FLUSH).
  - WR:
    - port_A_we=1, port_A_addr=wr_ptr, port_A_data_in=packed word.
    - Then wr_ptr+=4, lane=0; resume EXPAND, or the RD_REQ/FLUSH decision if the entry is finished.
  - FLUSH:
    - If lane!=0, write the partial word for one cycle (we=1), with unused upper lanes 0.
    - Then go to DONE; message_size is not rounded up.
  - DONE: done=1 and held until the cycle after the next start is accepted.
- port_A_we is high only during WR and the FLUSH write cycle, and only for one cycle per word.
- Outside write cycles, port_A_addr holds the read pointer.
- start while busy (RD_REQ..FLUSH) is ignored.
- Source/destination overlap: undefined. Address wrap past 0xFFFC rolls over to 0x0000.
- Throughput: 1 byte/cycle in EXPAND, plus 1 write cycle per 4 bytes, plus 2 cycles per compressed word read.

Decomposition:
- Shared package rle_pkg:
  - state enum;
  - entry field constants: BYTE_MSB=15, BYTE_LSB=8, CNT_MSB=7, CNT_LSB=0;
  - ENTRIES_PER_WORD=2, BYTES_PER_WORD=4.
  - The encoder shares this package.
- One natural sub-module, rld_pack: a 4-lane byte assembler with lane counter, full flag, zero-filled partial output and clear.

Test Plan:
- Single entry: mem[rle_addr]=0x0000_4103, rle_size=4 -> one write of 0x0041_4141 at message_addr; message_size=3; done=1.
- Two entries: word 0x4202_4102, rle_size=4 -> one write of 0x4242_4141; message_size=4; no FLUSH write.
- Long run: entry {0x5A, 0xFF} -> 63 writes of 0x5A5A_5A5A plus a final write of 0x005A_5A5A; message_size=255.
- Empty frame: rle_size=0 -> done within 2 cycles; port_A_we never high; message_size=0.
- Multi-word with padding: words 0x4302_4201, 0x0000_4401, rle_size=8 -> bytes 42 43 43 44; one write of 0x4443_4342; message_size=4.
- Abort and restart: start pulsed while busy is ignored. nreset low during EXPAND -> we=0 from that edge, done=0, message_size=0. A new start then decodes correctly.
